// File: rtl/multi_tc_pkg.sv
// Shared definitions for the multi_tc timer/counter: register offsets, MODE codes, CTRL fields, FSM states.
// Optional build macro MULTI_TC_PRESCALE_EN adds CTRL[15:8] prescale (PS) per channel.
package multi_tc_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_PS_LSB   = 8;
  localparam int CTRL_PS_MSB   = 15;
  localparam int PS_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2
  } state_e;

  // Only 01 reloads; 00 and both 1x encodings behave as one-shot.
  function automatic logic is_auto(input logic [1:0] mode);
    return (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/multi_tc_ch.sv
// One timer/counter channel: CTRL/PRESET/COUNT/STATUS registers, IDLE/LOAD/CNT FSM, optional prescaler.
// Build macro MULTI_TC_PRESCALE_EN enables the CTRL[15:8] prescale field.
module multi_tc_ch
  import multi_tc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_din,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_en;
  logic               r_im;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_preset;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_pend;
  logic               w_expire;
  logic               w_tick;
  logic               w_ctrl_we;
  logic               w_preset_we;
  logic               w_status_we;
  logic [31:0]        w_ctrl_rd;
  logic               w_unused;

  assign w_ctrl_we   = i_we && (i_off == OFF_CTRL);
  assign w_preset_we = i_we && (i_off == OFF_PRESET);
  assign w_status_we = i_we && (i_off == OFF_STATUS);
  assign w_unused    = ^i_din;

`ifdef MULTI_TC_PRESCALE_EN
  logic [PS_W-1:0] r_ps;
  logic [PS_W-1:0] r_ps_cnt;

  assign w_tick    = (r_ps_cnt == r_ps);
  assign w_ctrl_rd = {16'h0000, r_ps, 4'h0, r_im, r_mode, r_en};

  // Prescale counter runs only while actively counting and wraps after each tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ps_cnt <= {PS_W{1'b0}};
    end else if ((r_state != ST_CNT) || !r_en || w_tick) begin
      r_ps_cnt <= {PS_W{1'b0}};
    end else begin
      r_ps_cnt <= r_ps_cnt + 8'd1;
    end
  end
`else
  assign w_tick    = 1'b1;
  assign w_ctrl_rd = {28'h0000000, r_im, r_mode, r_en};
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and count; auto-reload re-arms through IDLE so each period equals the P+2 start latency.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_expire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_en) w_state_nxt = ST_LOAD;
        else      w_state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_tick) begin
          w_state_nxt = ST_CNT;
        end else if (r_count > CNT_W'(1)) begin
          w_count_nxt = r_count - CNT_W'(1);
        end else begin
          w_count_nxt = {CNT_W{1'b0}};
          w_expire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers; CPU CTRL write beats the one-shot EN clear, expiry beats the W1C clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en     <= 1'b0;
      r_mode   <= 2'b00;
      r_im     <= 1'b0;
      r_preset <= {CNT_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_pend   <= 1'b0;
`ifdef MULTI_TC_PRESCALE_EN
      r_ps     <= {PS_W{1'b0}};
`endif
    end else begin
      r_count <= w_count_nxt;
      if (w_ctrl_we) begin
        r_en   <= i_din[CTRL_EN_BIT];
        r_mode <= i_din[CTRL_MODE_MSB:CTRL_MODE_LSB];
        r_im   <= i_din[CTRL_IM_BIT];
`ifdef MULTI_TC_PRESCALE_EN
        r_ps   <= i_din[CTRL_PS_MSB:CTRL_PS_LSB];
`endif
      end else if (w_expire && !is_auto(r_mode)) begin
        r_en <= 1'b0;
      end
      if (w_preset_we) begin
        r_preset <= i_din[CNT_W-1:0];
      end
      if (w_expire) begin
        r_pend <= 1'b1;
      end else if (w_status_we && i_din[0]) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Register read select within the channel.
  always_comb begin
    o_rdata = 32'h00000000;
    case (i_off)
      OFF_CTRL:   o_rdata = w_ctrl_rd;
      OFF_PRESET: o_rdata = 32'(r_preset);
      OFF_COUNT:  o_rdata = 32'(r_count);
      OFF_STATUS: o_rdata = {31'h00000000, r_pend};
      default:    o_rdata = 32'h00000000;
    endcase
  end

  assign o_irq = r_pend & r_im;

endmodule

// File: rtl/multi_tc.sv
// N-channel memory-mapped timer/counter: word decode, channel read mux and IRQ OR-reduction.
// Build macro MULTI_TC_PRESCALE_EN enables per-channel prescale in CTRL[15:8].
module multi_tc
  import multi_tc_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  input  logic              we,
  output logic [31:0]       dout,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  logic [ADDR_W-1:0] w_ch_idx;
  logic [1:0]        w_off;
  logic [31:0]       w_ch_rd [NUM_CH];

  assign w_ch_idx = addr >> 2;
  assign w_off    = addr[1:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    multi_tc_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_we    (we && (w_ch_idx == ADDR_W'(g))),
      .i_off   (w_off),
      .i_din   (din),
      .o_rdata (w_ch_rd[g]),
      .o_irq   (irq_vec[g])
    );
  end

  // Channel read mux; addresses beyond the last channel match nothing and read zero.
  always_comb begin
    dout = 32'h00000000;
    for (int i = 0; i < NUM_CH; i++) begin
      dout = dout | ((w_ch_idx == ADDR_W'(i)) ? w_ch_rd[i] : 32'h00000000);
    end
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_multi_tc.sv
// Scoreboard bench for multi_tc: expected values queued at stimulus time, popped when the DUT is sampled.
module tb_multi_tc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  addr;
  logic [31:0] din;
  logic        we;
  logic [31:0] dout;
  logic [1:0]  irq_vec;
  logic        irq;

  logic [1:0]  addr8;
  logic [31:0] din8;
  logic        we8;
  logic [31:0] dout8;
  logic [0:0]  irq_vec8;
  logic        irq8;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q_exp [$];
  logic [31:0] got;
  logic [31:0] exp_v;

  multi_tc #(.NUM_CH(2), .CNT_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(rst_n), .addr(addr), .din(din), .we(we),
    .dout(dout), .irq_vec(irq_vec), .irq(irq)
  );

  multi_tc #(.NUM_CH(1), .CNT_W(8), .ADDR_W(2)) dut8 (
    .clk(clk), .reset(rst_n), .addr(addr8), .din(din8), .we(we8),
    .dout(dout8), .irq_vec(irq_vec8), .irq(irq8)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; din = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic wr8(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr8 = a; din8 = d; we8 = 1'b1;
    @(posedge clk); #1;
    we8 = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a; #1;
    d = dout;
  endtask

  task automatic test_reset();
    q_exp.push_back(32'h0);
    got = {29'h0, irq, irq_vec};
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_irq: got 0x%0h expected 0x%0h", got, exp_v); end
    for (int a = 0; a < 32; a++) begin
      q_exp.push_back(32'h0);
      rd(5'(a), got);
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL reset_rd[%0d]: got 0x%0h expected 0x%0h", a, got, exp_v); end
    end
  endtask

  task automatic test_unmapped();
    wr(5'd8, 32'h0000_000F);
    wr(5'd9, 32'h0000_0005);
    q_exp.push_back(32'h0); q_exp.push_back(32'h0); q_exp.push_back(32'h0); q_exp.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      rd((i == 0) ? 5'd8 : (i == 1) ? 5'd9 : (i == 2) ? 5'd0 : 5'd1, got);
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL unmapped[%0d]: got 0x%0h expected 0x%0h", i, got, exp_v); end
    end
  endtask

  task automatic test_oneshot();
    wr(5'd1, 32'd5);
    wr(5'd0, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      q_exp.push_back((k >= 7) ? 32'd1 : 32'd0);
      q_exp.push_back((k < 2 || k >= 7) ? 32'd0 : 32'(7 - k));
    end
    addr = 5'd2;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      got = {31'h0, irq_vec[0]};
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_irq k=%0d: got %0d expected %0d", k, got, exp_v); end
      got = dout;
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_count k=%0d: got %0d expected %0d", k, got, exp_v); end
    end
    q_exp.push_back(32'h8); q_exp.push_back(32'h1);
    rd(5'd0, got);
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_ctrl: got 0x%0h expected 0x%0h", got, exp_v); end
    rd(5'd3, got);
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_status: got 0x%0h expected 0x%0h", got, exp_v); end
    wr(5'd3, 32'h1);
    q_exp.push_back(32'h0);
    got = {31'h0, irq};
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_w1c_irq: got %0d expected %0d", got, exp_v); end
  endtask

  task automatic test_autoreload();
    wr(5'd5, 32'd3);
    wr(5'd4, 32'hB);
    for (int k = 1; k <= 6; k++) q_exp.push_back((k >= 5) ? 32'd1 : 32'd0);
    addr = 5'd6;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      got = {31'h0, irq_vec[1]};
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ar_first k=%0d: got %0d expected %0d", k, got, exp_v); end
    end
    wr(5'd7, 32'h1);
    q_exp.push_back(32'd0); q_exp.push_back(32'd0); q_exp.push_back(32'd0);
    for (int k = 7; k <= 9; k++) begin
      if (k > 7) begin @(posedge clk); #1; end
      got = {31'h0, irq_vec[1]};
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ar_cleared k=%0d: got %0d expected %0d", k, got, exp_v); end
    end
    wr(5'd7, 32'h1);
    q_exp.push_back(32'd1);
    got = {31'h0, irq_vec[1]};
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ar_set_beats_w1c: got %0d expected %0d", got, exp_v); end
    for (int k = 11; k <= 15; k++) begin
      q_exp.push_back(32'd1);
      q_exp.push_back((k == 11 || k == 15) ? 32'd0 : 32'(15 - k));
    end
    addr = 5'd6;
    for (int k = 11; k <= 15; k++) begin
      @(posedge clk); #1;
      got = {31'h0, irq_vec[1]};
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ar_pend k=%0d: got %0d expected %0d", k, got, exp_v); end
      got = dout;
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ar_count k=%0d: got %0d expected %0d", k, got, exp_v); end
    end
    wr(5'd7, 32'h1);
    wr(5'd4, 32'h0);
    for (int k = 18; k <= 20; k++) begin q_exp.push_back(32'd3); q_exp.push_back(32'd0); end
    addr = 5'd6;
    for (int k = 18; k <= 20; k++) begin
      @(posedge clk); #1;
      got = dout;
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ar_frozen_count k=%0d: got %0d expected %0d", k, got, exp_v); end
      got = {31'h0, irq_vec[1]};
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL ar_stopped_pend k=%0d: got %0d expected %0d", k, got, exp_v); end
    end
  endtask

  task automatic test_mask_indep();
    wr(5'd5, 32'd10);
    wr(5'd1, 32'd4);
    wr(5'd4, 32'h1);
    wr(5'd0, 32'h1);
    for (int j = 2; j <= 11; j++) begin q_exp.push_back(32'(12 - j)); q_exp.push_back(32'd0); end
    addr = 5'd6;
    for (int j = 2; j <= 11; j++) begin
      @(posedge clk); #1;
      got = dout;
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL indep_ch1_count j=%0d: got %0d expected %0d", j, got, exp_v); end
      got = {30'h0, irq_vec};
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL masked_irq_vec j=%0d: got 0x%0h expected 0x%0h", j, got, exp_v); end
    end
    q_exp.push_back(32'h1); q_exp.push_back(32'h0);
    rd(5'd3, got);
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL masked_status: got 0x%0h expected 0x%0h", got, exp_v); end
    rd(5'd0, got);
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL masked_ctrl: got 0x%0h expected 0x%0h", got, exp_v); end
    wr(5'd4, 32'h1);
    q_exp.push_back(32'h1); q_exp.push_back(32'h1);
    rd(5'd4, got);
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ctrl_write_wins: got 0x%0h expected 0x%0h", got, exp_v); end
    rd(5'd7, got);
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ch1_expiry_pend: got 0x%0h expected 0x%0h", got, exp_v); end
    wr(5'd4, 32'h0);
    wr(5'd7, 32'h1);
    wr(5'd3, 32'h1);
    q_exp.push_back(32'h0);
    got = {29'h0, irq, irq_vec};
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL cleanup_irq: got 0x%0h expected 0x%0h", got, exp_v); end
  endtask

  task automatic test_edge();
    logic [31:0] tr [14];
    wr(5'd1, 32'd0);
    wr(5'd0, 32'h9);
    for (int k = 1; k <= 3; k++) q_exp.push_back((k == 3) ? 32'd1 : 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      got = {31'h0, irq_vec[0]};
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL preset0_irq k=%0d: got %0d expected %0d", k, got, exp_v); end
    end
    wr(5'd3, 32'h1);
    tr = '{32'd0, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2};
    wr(5'd1, 32'd6);
    wr(5'd0, 32'h3);
    for (int k = 1; k <= 14; k++) q_exp.push_back(tr[k-1]);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) begin addr = 5'd1; din = 32'd2; we = 1'b1; end
      else begin we = 1'b0; end
      @(posedge clk); #1;
      we = 1'b0; addr = 5'd2; #1;
      got = dout;
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL preset_rewrite k=%0d: got %0d expected %0d", k, got, exp_v); end
    end
    wr(5'd0, 32'h0);
    wr(5'd3, 32'h1);
  endtask

  task automatic test_cnt_w8();
    wr8(2'd1, 32'h0000_01FF);
    q_exp.push_back(32'h0000_00FF);
    addr8 = 2'd1; #1; got = dout8;
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL w8_preset: got 0x%0h expected 0x%0h", got, exp_v); end
    wr8(2'd0, 32'hFFFF_FFFE);
`ifdef MULTI_TC_PRESCALE_EN
    q_exp.push_back(32'h0000_FF0E);
`else
    q_exp.push_back(32'h0000_000E);
`endif
    addr8 = 2'd0; #1; got = dout8;
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL w8_ctrl_bits: got 0x%0h expected 0x%0h", got, exp_v); end
    wr8(2'd2, 32'h0000_0055);
    q_exp.push_back(32'h0);
    addr8 = 2'd2; #1; got = dout8;
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL w8_count_ro: got 0x%0h expected 0x%0h", got, exp_v); end
  endtask

`ifdef MULTI_TC_PRESCALE_EN
  task automatic test_prescale();
    wr(5'd1, 32'd2);
    wr(5'd0, 32'h0000_0301);
    for (int k = 2; k <= 10; k++) q_exp.push_back((k <= 5) ? 32'd2 : (k <= 9) ? 32'd1 : 32'd0);
    addr = 5'd2;
    @(posedge clk); #1;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      got = dout;
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL prescale_count k=%0d: got %0d expected %0d", k, got, exp_v); end
    end
    q_exp.push_back(32'h0000_0300);
    rd(5'd0, got);
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL prescale_ctrl: got 0x%0h expected 0x%0h", got, exp_v); end
    wr(5'd3, 32'h1);
    wr(5'd0, 32'h0);
  endtask
`endif

  task automatic test_async_reset();
    wr(5'd1, 32'd1000);
    wr(5'd0, 32'h1);
    wr(5'd5, 32'd0);
    wr(5'd4, 32'h9);
    repeat (5) @(posedge clk);
    #1;
    q_exp.push_back(32'h1);
    got = {31'h0, irq};
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL pre_reset_irq: got %0d expected %0d", got, exp_v); end
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    q_exp.push_back(32'h0);
    got = {29'h0, irq, irq_vec};
    exp_v = q_exp.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL async_reset_irq: got 0x%0h expected 0x%0h", got, exp_v); end
    for (int a = 0; a < 32; a++) begin
      q_exp.push_back(32'h0);
      rd(5'(a), got);
      exp_v = q_exp.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL async_reset_rd[%0d]: got 0x%0h expected 0x%0h", a, got, exp_v); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    addr = 5'd0; din = 32'h0; we = 1'b0;
    addr8 = 2'd0; din8 = 32'h0; we8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_unmapped();
    test_oneshot();
    test_autoreload();
    test_mask_indep();
    test_edge();
    test_cnt_w8();
`ifdef MULTI_TC_PRESCALE_EN
    test_prescale();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
